// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART, TX/RX FIFOs, 16x oversampled baud tick.
// Define UART_PARITY_EN to add one even-parity bit per frame.
`timescale 1ns/1ps
module uart_fifo_core #(
    parameter int BAUD_DIV   = 326,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          tx_busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [11:0] baud_cnt;
    logic        tick;

    assign tick = (baud_cnt == 12'(BAUD_DIV - 1));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)    baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + 12'd1;
    end

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]          tx_wr, tx_rd;
    logic                 tx_push, tx_pop, tx_empty, tx_full;

    assign tx_level = tx_wr - tx_rd;
    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_level == LW'(FIFO_DEPTH));
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;

    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
        end
    end

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA,
`ifdef UART_PARITY_EN
        T_PAR,
`endif
        T_STOP
    } tx_state_t;

    tx_state_t            tx_st;
    logic [3:0]           tx_tk;
    logic [2:0]           tx_bit;
    logic                 tx_stop_n;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_bit_end, tx_last_stop;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end   = tick && (tx_tk == 4'd15);
    assign tx_last_stop = (tx_stop_n == 1'(STOP_BITS - 1));
    // Popping straight out of the last stop bit gives gap-free back-to-back frames
    assign tx_pop = tick && !tx_empty &&
                    ((tx_st == T_IDLE) ||
                     ((tx_st == T_STOP) && (tx_tk == 4'd15) && tx_last_stop));
    assign tx_busy = (tx_st != T_IDLE) || !tx_empty;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_st     <= T_IDLE;
            uart_tx   <= 1'b1;
            tx_tk     <= '0;
            tx_bit    <= '0;
            tx_stop_n <= 1'b0;
            tx_sh     <= '0;
`ifdef UART_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            if (tick && tx_st != T_IDLE) tx_tk <= tx_tk + 4'd1;
            if (tx_pop) begin
                tx_st     <= T_START;
                uart_tx   <= 1'b0;
                tx_sh     <= tx_mem[tx_rd[AW-1:0]];
                tx_tk     <= '0;
                tx_bit    <= '0;
                tx_stop_n <= 1'b0;
`ifdef UART_PARITY_EN
                tx_par    <= ^tx_mem[tx_rd[AW-1:0]];
`endif
            end else if (tx_bit_end) begin
                unique case (tx_st)
                    T_START: begin
                        tx_st   <= T_DATA;
                        uart_tx <= tx_sh[0];
                    end
                    T_DATA: begin
                        if (tx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_st   <= T_PAR;
                            uart_tx <= tx_par;
`else
                            tx_st   <= T_STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= tx_sh >> 1;
                            uart_tx <= tx_sh[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    T_PAR: begin
                        tx_st   <= T_STOP;
                        uart_tx <= 1'b1;
                    end
`endif
                    T_STOP: begin
                        if (tx_last_stop) begin
                            tx_st   <= T_IDLE;
                            uart_tx <= 1'b1;
                        end else begin
                            tx_stop_n <= tx_stop_n + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [1:0] rx_sync;
    logic       rx_prev, rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]          rx_wr, rx_rd;
    logic                 rx_push, rx_pop, rx_full, rx_stop_ok;
    logic [DATA_BITS-1:0] r_sh;

    assign rx_level = rx_wr - rx_rd;
    assign rx_valid = (rx_wr != rx_rd);
    assign rx_full  = (rx_level == LW'(FIFO_DEPTH));
    assign rx_pop   = rx_ready && rx_valid;
    assign rx_data  = rx_valid ? rx_mem[rx_rd[AW-1:0]] : '0;

    always_ff @(posedge sysclk) begin
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= r_sh;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
        end
    end

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
        R_PAR,
`endif
        R_STOP, R_WAIT
    } rx_state_t;

    rx_state_t  r_st;
    logic [3:0] r_tk;
    logic [2:0] r_bit;
    logic       r_samp;
`ifdef UART_PARITY_EN
    logic       r_perr;
`endif

    assign r_samp     = tick && (r_tk == 4'd15);
    assign rx_stop_ok = (r_st == R_STOP) && r_samp && rx_s;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign rx_push    = rx_stop_ok && (!rx_full || rx_pop);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_st      <= R_IDLE;
            r_tk      <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            r_perr     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick) r_tk <= r_tk + 4'd1;
            unique case (r_st)
                R_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        r_st  <= R_START;
                        r_tk  <= '0;
                        r_bit <= '0;
                    end
                end
                R_START: begin
                    if (tick && r_tk == 4'd7) begin
                        if (rx_s) begin
                            r_st <= R_IDLE;
                        end else begin
                            r_st <= R_DATA;
                            r_tk <= '0;
                        end
                    end
                end
                R_DATA: begin
                    if (r_samp) begin
                        r_sh <= {rx_s, r_sh[DATA_BITS-1:1]};
                        if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            r_st <= R_PAR;
`else
                            r_st <= R_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                R_PAR: begin
                    if (r_samp) begin
                        r_perr <= rx_s ^ (^r_sh);
                        r_st   <= R_STOP;
                    end
                end
`endif
                R_STOP: begin
                    if (r_samp) begin
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            r_st      <= R_WAIT;
                        end else begin
                            r_st    <= R_IDLE;
                            overrun <= !rx_push;
`ifdef UART_PARITY_EN
                            parity_err <= r_perr;
`endif
                        end
                    end
                end
                R_WAIT: begin
                    if (rx_s) r_st <= R_IDLE;
                end
                default: r_st <= R_IDLE;
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed checks of uart_fifo_core with BAUD_DIV=4.
// Bit period is 64 sysclk; serial frames are driven and sampled by the bench.
`timescale 1ns/1ps
module tb_uart_fifo_core;
    localparam int BIT = 64;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    wire        uart_rx;
    logic       uart_tx;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] tx_level, rx_level;
    logic       tx_busy, frame_err, overrun, parity_err;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;

    int vectors = 0;
    int errors  = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

    assign uart_rx = loop ? uart_tx : rx_drv;

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (overrun)    ov_cnt <= ov_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
    end

    uart_fifo_core #(
        .BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(16), .STOP_BITS(1)
    ) dut (
        .sysclk(sysclk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    task automatic push_byte(input logic [7:0] b);
        @(negedge sysclk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge sysclk);
        tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic par_flip);
        logic [10:0] fr;
        int nb;
        nb = PAR ? 11 : 10;
        fr = PAR ? {stop_v, (^b) ^ par_flip, b, 1'b0}
                 : {1'b0, stop_v, b, 1'b0};
        @(negedge sysclk);
        for (int i = 0; i < nb; i++) begin
            rx_drv = fr[i];
            repeat (BIT) @(negedge sysclk);
        end
        rx_drv = 1'b1;
        repeat (BIT) @(negedge sysclk);
    endtask

    task automatic wait_tx_fall(output bit ok);
        int t;
        t = 0;
        while (uart_tx === 1'b1 && t < 200) begin
            @(posedge sysclk); #1;
            t++;
        end
        ok = (t < 200);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        vectors++;
        if ({uart_tx, tx_ready, rx_valid, tx_busy, frame_err, overrun, parity_err}
            !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_flags got %b want 1100000",
                {uart_tx, tx_ready, rx_valid, tx_busy, frame_err, overrun, parity_err});
        end
        vectors++;
        if (tx_level !== 5'd0 || rx_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_levels got %0d/%0d want 0/0", tx_level, rx_level);
        end
        vectors++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data got %h want 00", rx_data);
        end
        reset = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_tx_frame;
        logic [7:0] b;
        bit ok;
        int n;
        b = 8'h55;
        push_byte(b);
        wait_tx_fall(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL tx_start_timeout got no start bit want start bit");
        end
        n = 0;
        while (uart_tx === 1'b0 && n < 200) begin
            @(posedge sysclk); #1;
            n++;
        end
        vectors++;
        if (n !== BIT) begin
            errors++;
            $display("FAIL tx_start_len got %0d want %0d", n, BIT);
        end
        repeat (BIT / 2) @(posedge sysclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (uart_tx !== b[i]) begin
                errors++;
                $display("FAIL tx_data_bit%0d got %b want %b", i, uart_tx, b[i]);
            end
            repeat (BIT) @(posedge sysclk);
            #1;
        end
        vectors++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL tx_stop got tx=%b busy=%b want tx=1 busy=1", uart_tx, tx_busy);
        end
        repeat (BIT) @(posedge sysclk);
        #1;
        vectors++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL tx_idle got tx=%b busy=%b want tx=1 busy=0", uart_tx, tx_busy);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        push_byte(8'hF0);
        push_byte(8'h0F);
        wait_tx_fall(ok);
        repeat (100) @(posedge sysclk);
        #3;
        vectors++;
        if (!ok || tx_level !== 5'd1) begin
            errors++;
            $display("FAIL midframe_pre got ok=%0d level=%0d want ok=1 level=1", ok, tx_level);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_level !== 5'd0) begin
            errors++;
            $display("FAIL midframe_reset got tx=%b busy=%b lvl=%0d want 1 0 0",
                uart_tx, tx_busy, tx_level);
        end
        @(negedge sysclk);
        reset = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_loopback;
        logic [7:0] exp [3];
        int t, f0;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA5;
        f0 = fe_cnt + ov_cnt + pe_cnt;
        loop = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(exp[i]);
        t = 0;
        while (rx_level !== 5'd3 && t < 5000) begin
            @(negedge sysclk);
            t++;
        end
        vectors++;
        if (rx_level !== 5'd3) begin
            errors++;
            $display("FAIL loop_level got %0d want 3", rx_level);
        end
        t = 0;
        while (tx_busy !== 1'b0 && t < 2000) begin
            @(negedge sysclk);
            t++;
        end
        loop = 1'b0;
        vectors++;
        if (fe_cnt + ov_cnt + pe_cnt !== f0) begin
            errors++;
            $display("FAIL loop_flags got %0d want %0d", fe_cnt + ov_cnt + pe_cnt, f0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            vectors++;
            if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin
                errors++;
                $display("FAIL loop_byte%0d got v=%b %h want v=1 %h",
                    i, rx_valid, rx_data, exp[i]);
            end
            rx_ready = 1'b1;
            @(negedge sysclk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_glitch;
        int f0;
        f0 = fe_cnt + ov_cnt + pe_cnt;
        @(negedge sysclk);
        rx_drv = 1'b0;
        repeat (16) @(negedge sysclk);
        rx_drv = 1'b1;
        repeat (300) @(negedge sysclk);
        vectors++;
        if (rx_level !== 5'd0 || fe_cnt + ov_cnt + pe_cnt !== f0) begin
            errors++;
            $display("FAIL glitch got lvl=%0d flags=%0d want lvl=0 flags=%0d",
                rx_level, fe_cnt + ov_cnt + pe_cnt, f0);
        end
        send_frame(8'h3C, 1'b1, 1'b0);
        vectors++;
        if (rx_level !== 5'd1 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL glitch_recover got lvl=%0d %h want 1 3c", rx_level, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge sysclk);
        rx_ready = 1'b0;
    endtask

    task automatic test_frame_err;
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        vectors++;
        if (fe_cnt - fe0 !== 1 || ov_cnt !== ov0) begin
            errors++;
            $display("FAIL frame_err got fe=%0d ov=%0d want fe=1 ov=0",
                fe_cnt - fe0, ov_cnt - ov0);
        end
        vectors++;
        if (rx_level !== 5'd0) begin
            errors++;
            $display("FAIL frame_err_level got %0d want 0", rx_level);
        end
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
        vectors++;
        if (rx_level !== 5'd16 || ov_cnt !== ov0) begin
            errors++;
            $display("FAIL fill got lvl=%0d ov=%0d want 16 0", rx_level, ov_cnt - ov0);
        end
        send_frame(8'hEE, 1'b1, 1'b0);
        vectors++;
        if (ov_cnt - ov0 !== 1 || rx_level !== 5'd16 || rx_data !== 8'h10) begin
            errors++;
            $display("FAIL overrun got ov=%0d lvl=%0d head=%h want 1 16 10",
                ov_cnt - ov0, rx_level, rx_data);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge sysclk);
            vectors++;
            if (rx_data !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL drain%0d got %h want %h", i, rx_data, 8'h10 + 8'(i));
            end
            rx_ready = 1'b1;
            @(negedge sysclk);
            rx_ready = 1'b0;
        end
        @(negedge sysclk);
        vectors++;
        if (rx_valid !== 1'b0 || rx_level !== 5'd0) begin
            errors++;
            $display("FAIL drained got v=%b lvl=%0d want 0 0", rx_valid, rx_level);
        end
    endtask

    task automatic test_parity;
`ifdef UART_PARITY_EN
        int pe0;
        bit ok;
        pe0 = pe_cnt;
        send_frame(8'h01, 1'b1, 1'b1);
        vectors++;
        if (pe_cnt - pe0 !== 1 || rx_level !== 5'd1 || rx_data !== 8'h01) begin
            errors++;
            $display("FAIL parity_rx got pe=%0d lvl=%0d %h want 1 1 01",
                pe_cnt - pe0, rx_level, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge sysclk);
        rx_ready = 1'b0;
        push_byte(8'h03);
        wait_tx_fall(ok);
        repeat (BIT / 2 + 9 * BIT) @(posedge sysclk);
        #1;
        vectors++;
        if (!ok || uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL parity_tx got %b want 0", uart_tx);
        end
        repeat (BIT) @(posedge sysclk);
        #1;
        vectors++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL parity_tx_stop got %b want 1", uart_tx);
        end
        repeat (2 * BIT) @(posedge sysclk);
`else
        vectors++;
        if (pe_cnt !== 0) begin
            errors++;
            $display("FAIL parity_tied got %0d pulses want 0", pe_cnt);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_reset_midframe;
        test_loopback;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_parity;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Parametrised full-duplex UART with TX and RX FIFOs. The whole block runs in the single sysclk domain; there are no derived or ripple clocks. It gives the CPU bus glue a valid/ready byte-stream interface plus status flags, in place of the one-byte register handshake. Baud timing comes from a 16x oversampling tick generated from sysclk.

Parameters:
BAUD_DIV, 326, sysclk cycles per 16x tick (50 MHz / (16*9600)); legal range 1..4095.
DATA_BITS, 8, data bits per frame; legal range 5..8.
FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, minimum 2.
STOP_BITS, 1, number of stop bits transmitted (1 or 2); RX always checks exactly one stop bit.

Ports:
sysclk  in  1  system clock
reset  in  1  asynchronous, active-low reset
uart_rx  in  1  serial input; asynchronous to sysclk
uart_tx  out  1  serial output; idles high
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_BITS  head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer pops the RX FIFO head
tx_level  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_level  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy
tx_busy  out  1  shifter active, or TX FIFO non-empty
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: received byte dropped because RX FIFO full
parity_err  out  1  one-cycle pulse: parity mismatch (held 0 without UART_PARITY_EN)

Behaviour:
- Reset (reset=0, async): uart_tx=1; tx_ready=1; rx_valid=0; tx_busy=0; levels=0; all pulses=0; rx_data=0; tick counter=0; both FSMs IDLE; FIFO pointers cleared. Reset mid-frame aborts the frame immediately, with no glitch below idle-high on uart_tx.
- Tick: counter 0..BAUD_DIV-1; tick=1 for one sysclk when counter wraps. One bit period = 16 ticks.
- FIFOs: synchronous, registered pointers with an extra wrap bit. Push when valid&ready; pop when the consumer handshakes.
  - Simultaneous push and pop: level unchanged. When full, this is allowed only on the RX side, because the internal push check happens after the pop.
  - rx_data is the combinational head entry and is valid in the same cycle rx_valid=1.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - In IDLE, with the FIFO non-empty, pop on the next tick and drive start bit 0.
  - DATA: LSB first, DATA_BITS bits.
  - STOP: drive 1 for STOP_BITS periods.
  - Each state is held 16 ticks per bit. Back-to-back frames have no extra idle gap.
- RX path: uart_rx passes through a 2-flop synchroniser (latency 2 sysclk) before use.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a falling edge of the synchronised input resets the sample counter.
  - START: resample at tick 8. If the line is high, treat it as a false start and return to IDLE with no flags.
  - DATA: each bit sampled at tick count 8 of its period (mid-bit), LSB first.
  - STOP: sampled mid-bit. If low, pulse frame_err, discard the byte, and wait for the line to go high before IDLE. If high and the FIFO is full, pulse overrun and drop the byte; otherwise push the byte. Return to IDLE right after the stop sample (half-bit early) so tight back-to-back frames are accepted.
- Pulse flags are single sysclk cycles. Several flags may assert in the same cycle.
- Levels saturate by construction: 0..FIFO_DEPTH, never wrap.

Optional Feature:
UART_PARITY_EN:
- Defined: one even-parity bit after the data bits on TX (XOR of data bits). RX samples that bit; on mismatch, pulse parity_err and still push the byte (frame_err takes precedence and discards the byte).
- Undefined: no parity state in either FSM; parity_err tied to 0; frame is start + DATA_BITS + stop.

Test Plan:
- Reset, then push 0x55 with BAUD_DIV=4 -> uart_tx: 0 for 64 sysclk, then 1,0,1,0,1,0,1,0 (64 each), then 1; tx_busy falls after the stop bit.
- Loopback uart_tx->uart_rx, push 0x00,0xFF,0xA5 -> rx_data sequence 0x00,0xFF,0xA5; rx_level reaches 3; no error flags.
- Drive a 16-sysclk low glitch on uart_rx (BAUD_DIV=4) -> no RX push, no flags, FSM back to IDLE.
- Send a frame with stop bit 0 -> exactly one frame_err pulse; rx_level unchanged.
- Fill RX FIFO (16 frames, rx_ready=0), send a 17th -> one overrun pulse, rx_level=16, head still the first byte.
- With UART_PARITY_EN, send 0x01 with parity bit 0 -> parity_err pulse, 0x01 pushed; TX of 0x03 emits parity bit 0.
